// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle LEGv8 controller: FSM states, instruction
// classes, opcode constants and the static datapath control bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        NOP, RTYPE, LDUR, STUR, CBZ, CBNZ, B, ILLEGAL
    } iclass_t;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    // Branch opcodes only fix their upper bits; the rest are don't-care.
    localparam logic [7:0]  OP_CBZ_HI  = 8'hB4;
    localparam logic [7:0]  OP_CBNZ_HI = 8'hB5;
    localparam logic [5:0]  OP_B_HI    = 6'b000101;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_LDUR  = ctrl_t'(9'b0_1_1_1_1_0_0_00);
    localparam ctrl_t CTRL_STUR  = ctrl_t'(9'b1_1_0_0_0_1_0_00);
    localparam ctrl_t CTRL_CB    = ctrl_t'(9'b1_0_0_0_0_0_1_01);
    localparam ctrl_t CTRL_RTYPE = ctrl_t'(9'b0_0_0_1_0_0_0_10);
    localparam ctrl_t CTRL_B     = ctrl_t'(9'b0_0_0_0_0_0_1_01);

endpackage

// File: rtl/op_classify.sv
// Combinational opcode decoder: maps the IR opcode field to an instruction
// class and its static control bundle; optional branches decode as illegal.
module op_classify
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 11,
    parameter bit EN_CBNZ = 1'b1,
    parameter bit EN_B    = 1'b1
) (
    input  logic [OP_W-1:0] Op,
    output iclass_t         iclass,
    output ctrl_t           ctrl
);

    always_comb begin
        iclass = ILLEGAL;
        ctrl   = '0;
        if (Op == OP_ADD || Op == OP_SUB || Op == OP_AND || Op == OP_ORR) begin
            iclass = RTYPE;
            ctrl   = CTRL_RTYPE;
        end else if (Op == OP_LDUR) begin
            iclass = LDUR;
            ctrl   = CTRL_LDUR;
        end else if (Op == OP_STUR) begin
            iclass = STUR;
            ctrl   = CTRL_STUR;
        end else if (Op[OP_W-1 -: 8] == OP_CBZ_HI) begin
            iclass = CBZ;
            ctrl   = CTRL_CB;
        end else if (EN_CBNZ && Op[OP_W-1 -: 8] == OP_CBNZ_HI) begin
            iclass = CBNZ;
            ctrl   = CTRL_CB;
        end else if (EN_B && Op[OP_W-1 -: 6] == OP_B_HI) begin
            iclass = B;
            ctrl   = CTRL_B;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control unit with mem_ready handshake, wait timeout and
// a sticky error state.
//   state    | meaning
//   S_FETCH  | read instruction memory, load IR on mem_ready
//   S_DECODE | classify opcode, latch static controls
//   S_EXEC   | ALU operation for R-type / address for LDUR, STUR
//   S_MEM    | data memory access, held until mem_ready
//   S_WB     | register write-back, advance PC
//   S_BRANCH | resolve branch, advance PC
//   S_ERR    | illegal opcode or timeout; left only through reset
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W        = 11,
    parameter int TIMEOUT_CYC = 16,
    parameter bit EN_CBNZ     = 1'b1,
    parameter bit EN_B        = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            Reg2Loc,
    output logic            ALUSrc,
    output logic            MemtoReg,
    output logic            Branch,
    output logic [1:0]      ALUOp,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCSrc,
    output logic            busy,
    output logic            error
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    iclass_t          iclass_q;
    iclass_t          dec_class;
    ctrl_t            ctrl_q;
    ctrl_t            dec_ctrl;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;
    logic             taken;

    op_classify #(
        .OP_W   (OP_W),
        .EN_CBNZ(EN_CBNZ),
        .EN_B   (EN_B)
    ) u_classify (
        .Op    (Op),
        .iclass(dec_class),
        .ctrl  (dec_ctrl)
    );

    // Wait timer counts down the remaining stall cycles; it reloads whenever
    // the FSM is not stalled, which covers every state change.
    assign waiting = (state == S_FETCH || state == S_MEM) && !mem_ready;
    assign timeout = (TIMEOUT_CYC != 0) && waiting && (wait_cnt == '0);

    always_comb begin
        taken = 1'b0;
        case (iclass_q)
            CBZ:     taken = zero;
            CBNZ:    taken = !zero;
            B:       taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            iclass_q <= NOP;
            ctrl_q   <= '0;
            wait_cnt <= CNT_LOAD;
        end else begin
            wait_cnt <= waiting ? wait_cnt - CNT_W'(1) : CNT_LOAD;
            case (state)
                S_FETCH: begin
                    if (mem_ready)    state <= S_DECODE;
                    else if (timeout) state <= S_ERR;
                end
                S_DECODE: begin
                    case (dec_class)
                        RTYPE, LDUR, STUR: begin
                            state    <= S_EXEC;
                            iclass_q <= dec_class;
                            ctrl_q   <= dec_ctrl;
                        end
                        CBZ, CBNZ, B: begin
                            state    <= S_BRANCH;
                            iclass_q <= dec_class;
                            ctrl_q   <= dec_ctrl;
                        end
                        default: state <= S_ERR;
                    endcase
                end
                S_EXEC: state <= (iclass_q == RTYPE) ? S_WB : S_MEM;
                S_MEM: begin
                    if (mem_ready) begin
                        if (iclass_q == LDUR) begin
                            state <= S_WB;
                        end else begin
                            state    <= S_FETCH;
                            iclass_q <= NOP;
                            ctrl_q   <= '0;
                        end
                    end else if (timeout) begin
                        state    <= S_ERR;
                        iclass_q <= NOP;
                        ctrl_q   <= '0;
                    end
                end
                S_WB, S_BRANCH: begin
                    state    <= S_FETCH;
                    iclass_q <= NOP;
                    ctrl_q   <= '0;
                end
                S_ERR:   state <= S_ERR;
                default: state <= S_ERR;
            endcase
        end
    end

    // Fetch-state outputs are qualified by reset so everything is low while
    // reset is held, even though the state register already sits in S_FETCH.
    always_comb begin
        Reg2Loc  = ctrl_q.reg2loc;
        ALUSrc   = ctrl_q.alusrc;
        MemtoReg = ctrl_q.memtoreg;
        Branch   = ctrl_q.branch;
        ALUOp    = ctrl_q.aluop;
        RegWrite = (state == S_WB) && ctrl_q.regwrite;
        MemRead  = (reset && state == S_FETCH) || (state == S_MEM && ctrl_q.memread);
        MemWrite = (state == S_MEM) && ctrl_q.memwrite;
        IRWrite  = reset && (state == S_FETCH) && mem_ready;
        PCWrite  = (state == S_WB) || (state == S_BRANCH) ||
                   (state == S_MEM && ctrl_q.memwrite && mem_ready);
        PCSrc    = (state == S_BRANCH) && taken;
        busy     = reset && !(state == S_FETCH && !mem_ready);
        error    = (state == S_ERR);
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed per-cycle vector table, hand-written
// corner sequences, and randomized instructions against a schedule model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       r2l, alusrc, m2r, br;
        logic [1:0] aluop;
        logic       rw, mr, mw, irw, pcw, pcs, busy, err;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [10:0] op;
        logic        z;
        logic        rdy;
        outs_t       exp;
        string       name;
    } vec_t;

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_CBNZ = 4, K_B = 5, K_ILL = 6;

    localparam logic [13:0] V_RST   = 14'b0000_00_000000_00;
    localparam logic [13:0] V_FRDY  = 14'b0000_00_010100_10;
    localparam logic [13:0] V_FWAIT = 14'b0000_00_010000_00;
    localparam logic [13:0] V_DEC   = 14'b0000_00_000000_10;
    localparam logic [13:0] V_ERR   = 14'b0000_00_000000_11;
    localparam logic [13:0] V_ST_E  = 14'b1100_00_000000_10;
    localparam logic [13:0] V_ST_MW = 14'b1100_00_001000_10;

    logic        clk;
    logic        reset;
    logic [10:0] Op;
    logic        zero;
    logic        mem_ready;
    wire  [13:0] w1, w2;
    outs_t       o1, o2;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[$];

    assign o1 = w1;
    assign o2 = w2;

    multicycle_ctrl dut1 (
        .clk(clk), .reset(reset), .Op(Op), .zero(zero), .mem_ready(mem_ready),
        .Reg2Loc(w1[13]), .ALUSrc(w1[12]), .MemtoReg(w1[11]), .Branch(w1[10]),
        .ALUOp(w1[9:8]), .RegWrite(w1[7]), .MemRead(w1[6]), .MemWrite(w1[5]),
        .IRWrite(w1[4]), .PCWrite(w1[3]), .PCSrc(w1[2]), .busy(w1[1]), .error(w1[0])
    );

    multicycle_ctrl #(.TIMEOUT_CYC(4), .EN_CBNZ(1'b0)) dut2 (
        .clk(clk), .reset(reset), .Op(Op), .zero(zero), .mem_ready(mem_ready),
        .Reg2Loc(w2[13]), .ALUSrc(w2[12]), .MemtoReg(w2[11]), .Branch(w2[10]),
        .ALUOp(w2[9:8]), .RegWrite(w2[7]), .MemRead(w2[6]), .MemWrite(w2[5]),
        .IRWrite(w2[4]), .PCWrite(w2[3]), .PCSrc(w2[2]), .busy(w2[1]), .error(w2[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] rnd_op();
        return 11'($urandom_range(0, 2047));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(input logic rst, input logic [10:0] op, input logic z,
                                input logic rdy, input logic [13:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endfunction

    // Instruction kind straight from the opcode bit patterns.
    function automatic int ref_kind(input logic [10:0] op, input bit en_cbnz);
        casez (op)
            11'h458, 11'h658, 11'h450, 11'h550: return K_R;
            11'h7C2:            return K_LD;
            11'h7C0:            return K_ST;
            11'b101_1010_0???:  return K_CBZ;
            11'b101_1010_1???:  return en_cbnz ? K_CBNZ : K_ILL;
            11'b000_101?_????:  return K_B;
            default:            return K_ILL;
        endcase
    endfunction

    function automatic outs_t ref_static(input int k);
        outs_t s;
        s = '0;
        case (k)
            K_LD:          begin s.alusrc = 1'b1; s.m2r = 1'b1; end
            K_ST:          begin s.r2l = 1'b1; s.alusrc = 1'b1; end
            K_CBZ, K_CBNZ: begin s.r2l = 1'b1; s.br = 1'b1; s.aluop = 2'b01; end
            K_B:           begin s.br = 1'b1; s.aluop = 2'b01; end
            K_R:           s.aluop = 2'b10;
            default:       s = '0;
        endcase
        return s;
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic [10:0] op, input logic z,
                        input bit sel2, input outs_t exp, input string name);
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = rdy; Op = op; zero = z;
        @(negedge clk);
        check(name, sel2 ? o2 : o1, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("reset1", o1, '0);
        check("reset2", o2, '0);
    endtask

    // One instruction on dut1: the expected cycle-by-cycle outputs follow from
    // the instruction kind, the chosen stall counts and the zero flag.
    task automatic run_instr(input logic [10:0] op, input logic z, input int fs, input int ms);
        int    k;
        outs_t st, e;
        k  = ref_kind(op, 1'b1);
        st = ref_static(k);
        for (int i = 0; i < fs; i++) step(1'b0, rnd_op(), rnd_bit(), 1'b0, V_FWAIT, "fetch_wait");
        step(1'b1, rnd_op(), rnd_bit(), 1'b0, V_FRDY, "fetch_done");
        step(rnd_bit(), op, rnd_bit(), 1'b0, V_DEC, "decode");
        if (k == K_CBZ || k == K_CBNZ || k == K_B) begin
            e = st; e.busy = 1'b1; e.pcw = 1'b1;
            e.pcs = (k == K_CBZ) ? z : (k == K_CBNZ) ? !z : 1'b1;
            step(rnd_bit(), rnd_op(), z, 1'b0, e, "branch");
        end else begin
            e = st; e.busy = 1'b1;
            step(rnd_bit(), rnd_op(), rnd_bit(), 1'b0, e, "exec");
            if (k != K_R) begin
                e.mr = (k == K_LD); e.mw = (k == K_ST);
                for (int i = 0; i < ms; i++) step(1'b0, rnd_op(), rnd_bit(), 1'b0, e, "mem_wait");
                e.pcw = (k == K_ST);
                step(1'b1, rnd_op(), rnd_bit(), 1'b0, e, "mem_done");
            end
            if (k != K_ST) begin
                e = st; e.busy = 1'b1; e.rw = 1'b1; e.pcw = 1'b1;
                step(rnd_bit(), rnd_op(), rnd_bit(), 1'b0, e, "writeback");
            end
        end
    endtask

    initial begin
        int mw_n, rw_n, pcw_n;
        logic [10:0] op;
        reset = 1'b0; Op = '0; zero = 1'b0; mem_ready = 1'b0;

        add(0, 11'h000, 0, 0, V_RST,  "tbl_reset");
        add(1, 11'h000, 0, 1, V_FRDY, "ld_f");
        add(1, 11'h7C2, 0, 0, V_DEC,  "ld_d");
        add(1, 11'h000, 0, 0, 14'b0110_00_000000_10, "ld_e");
        add(1, 11'h000, 0, 1, 14'b0110_00_010000_10, "ld_m");
        add(1, 11'h000, 0, 0, 14'b0110_00_100010_10, "ld_w");
        add(1, 11'h000, 0, 1, V_FRDY, "cbz_f");
        add(1, 11'h5A0, 0, 1, V_DEC,  "cbz_d");
        add(1, 11'h000, 1, 1, 14'b1001_01_000011_10, "cbz_taken");
        add(1, 11'h000, 1, 1, V_FRDY, "cbz0_f");
        add(1, 11'h5A7, 1, 1, V_DEC,  "cbz0_d");
        add(1, 11'h000, 0, 1, 14'b1001_01_000010_10, "cbz_not");
        add(1, 11'h000, 0, 1, V_FRDY, "cbnz_f");
        add(1, 11'h5A8, 0, 1, V_DEC,  "cbnz_d");
        add(1, 11'h000, 1, 1, 14'b1001_01_000010_10, "cbnz_not");
        add(1, 11'h000, 0, 1, V_FRDY, "cbnz1_f");
        add(1, 11'h5AF, 1, 1, V_DEC,  "cbnz1_d");
        add(1, 11'h000, 0, 1, 14'b1001_01_000011_10, "cbnz_taken");
        add(1, 11'h000, 0, 1, V_FRDY, "b_f");
        add(1, 11'h0BF, 0, 1, V_DEC,  "b_d");
        add(1, 11'h000, 0, 0, 14'b0001_01_000011_10, "b_br");
        add(1, 11'h000, 0, 1, V_FRDY, "add_f");
        add(1, 11'h458, 0, 1, V_DEC,  "add_d");
        add(1, 11'h000, 0, 1, 14'b0000_10_000000_10, "add_e");
        add(1, 11'h000, 0, 1, 14'b0000_10_100010_10, "add_w");
        add(1, 11'h000, 0, 0, V_FWAIT, "sub_fwait");
        add(1, 11'h000, 0, 1, V_FRDY, "sub_f");
        add(1, 11'h658, 0, 0, V_DEC,  "sub_d");
        add(1, 11'h000, 0, 0, 14'b0000_10_000000_10, "sub_e");
        add(1, 11'h000, 0, 0, 14'b0000_10_100010_10, "sub_w");
        add(1, 11'h000, 0, 1, V_FRDY, "ill_f");
        add(1, 11'h7FF, 0, 1, V_DEC,  "ill_d");
        add(1, 11'h000, 0, 1, V_ERR,  "ill_err");
        add(1, 11'h000, 0, 0, V_ERR,  "ill_sticky");
        add(0, 11'h000, 0, 1, V_RST,  "ill_reset");

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            @(posedge clk); #1;
            reset = tbl[i].rst; Op = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].rdy;
            @(negedge clk);
            check(tbl[i].name, o1, tbl[i].exp);
        end

        // STUR with three stalled memory cycles.
        do_reset();
        mw_n = 0; rw_n = 0; pcw_n = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            reset = 1'b1; Op = (c == 1) ? 11'h7C0 : rnd_op(); zero = rnd_bit();
            mem_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            mw_n += int'(o1.mw); rw_n += int'(o1.rw); pcw_n += int'(o1.pcw);
        end
        check_int("stur_memwrite_cycles", mw_n, 4);
        check_int("stur_regwrite_cycles", rw_n, 0);
        check_int("stur_pcwrite_cycles", pcw_n, 1);
        step(1'b1, rnd_op(), rnd_bit(), 1'b0, V_FRDY, "stur_next_fetch");

        // Reset asserted mid-cycle while STUR waits in memory.
        do_reset();
        step(1'b1, rnd_op(), 1'b0, 1'b0, V_FRDY,  "rs_f");
        step(1'b0, 11'h7C0,  1'b0, 1'b0, V_DEC,   "rs_d");
        step(1'b0, rnd_op(), 1'b0, 1'b0, V_ST_E,  "rs_e");
        step(1'b0, rnd_op(), 1'b0, 1'b0, V_ST_MW, "rs_m");
        #2 reset = 1'b0;
        #1 check("rs_async", o1, '0);
        step(1'b0, rnd_op(), 1'b0, 1'b0, V_FWAIT, "rs_after1");
        step(1'b0, rnd_op(), 1'b0, 1'b0, V_FWAIT, "rs_after2");

        // dut2: fetch timeout after four stalled cycles, sticky until reset.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, rnd_op(), rnd_bit(), 1'b1, V_FWAIT, "to_fetch_wait");
        for (int i = 0; i < 3; i++) step(i != 0, rnd_op(), rnd_bit(), 1'b1, V_ERR, "to_fetch_err");
        do_reset();
        // dut2: CBNZ disabled decodes as illegal, CBZ still works.
        step(1'b1, rnd_op(), 1'b0, 1'b1, V_FRDY, "nocbnz_f");
        step(1'b0, 11'h5A8,  1'b0, 1'b1, V_DEC,  "nocbnz_d");
        step(1'b1, rnd_op(), 1'b1, 1'b1, V_ERR,  "nocbnz_err");
        do_reset();
        step(1'b1, rnd_op(), 1'b0, 1'b1, V_FRDY, "cbz2_f");
        step(1'b1, 11'h5A3,  1'b0, 1'b1, V_DEC,  "cbz2_d");
        step(1'b1, rnd_op(), 1'b1, 1'b1, 14'b1001_01_000011_10, "cbz2_br");
        // dut2: memory-stage timeout during STUR.
        step(1'b1, rnd_op(), 1'b0, 1'b1, V_FRDY, "mto_f");
        step(1'b1, 11'h7C0,  1'b0, 1'b1, V_DEC,  "mto_d");
        step(1'b0, rnd_op(), 1'b0, 1'b1, V_ST_E, "mto_e");
        for (int i = 0; i < 4; i++) step(1'b0, rnd_op(), 1'b0, 1'b1, V_ST_MW, "mto_wait");
        step(1'b1, rnd_op(), 1'b0, 1'b1, V_ERR, "mto_err");

        // Randomized instruction stream on dut1.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 8))
                0: op = 11'h458;
                1: op = 11'h658;
                2: op = 11'h450;
                3: op = 11'h550;
                4: op = 11'h7C2;
                5: op = 11'h7C0;
                6: op = 11'h5A0 | 11'($urandom_range(0, 7));
                7: op = 11'h5A8 | 11'($urandom_range(0, 7));
                default: op = 11'h0A0 | 11'($urandom_range(0, 31));
            endcase
            run_instr(op, rnd_bit(), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
